// File: rtl/sdram_frame_reader.sv
// Streams one video frame per frame_start from the display bank into the line FIFO
// using space-checked SDRAM read bursts, then pulses vga_rise for the bank arbiter.
module sdram_frame_reader #(
  parameter int H_PIXELS   = 640,
  parameter int V_LINES    = 480,
  parameter int BURST_LEN  = 256,
  parameter int ADDR_W     = 20,
  parameter int FIFO_DEPTH = 1024
) (
  input  logic              clk,
  input  logic              rst_133,
  input  logic [1:0]        vga_bank,
  input  logic              frame_start,
  input  logic [10:0]       fifo_level,
  output logic              rd_req,
  output logic [1:0]        rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [8:0]        rd_len,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [15:0]       rd_data,
  output logic              fifo_wr_en,
  output logic [15:0]       fifo_wr_data,
  output logic              vga_rise,
  output logic              frame_skip,
  output logic              busy
);

  localparam int FRAME_WORDS = H_PIXELS * V_LINES;
  localparam int REM_W       = $clog2(FRAME_WORDS + 1);

  typedef enum logic [2:0] {IDLE, WAIT_SPACE, REQ, DATA, DONE} state_t;

  state_t              state_q, state_d;
  logic                rd_req_q, rd_req_d;
  logic [1:0]          bank_q, bank_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [8:0]          len_q, len_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [8:0]          cnt_q, cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [15:0]         wr_data_q, wr_data_d;
  logic                rise_q, rise_d;
  logic                skip_q, skip_d;
  logic [8:0]          cur_len;
  logic                space_ok;

  always_comb begin
    if (32'(rem_q) >= 32'(BURST_LEN)) cur_len = 9'(BURST_LEN);
    else                              cur_len = 9'(rem_q);
  end

  // A level above FIFO_DEPTH would underflow the subtraction, so treat it as no space.
  assign space_ok = (32'(fifo_level) <= 32'(FIFO_DEPTH)) &&
                    ((32'(FIFO_DEPTH) - 32'(fifo_level)) >= 32'(cur_len));

  always_comb begin
    state_d   = state_q;
    rd_req_d  = rd_req_q;
    bank_d    = bank_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    rise_d    = 1'b0;
    skip_d    = frame_start && (state_q != IDLE);
    wr_en_d   = rd_valid && (state_q == DATA);
    wr_data_d = wr_en_d ? rd_data : wr_data_q;

    unique case (state_q)
      IDLE: begin
        if (frame_start) begin
          bank_d  = vga_bank;
          addr_d  = '0;
          rem_d   = REM_W'(FRAME_WORDS);
          state_d = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          rd_req_d = 1'b1;
          len_d    = cur_len;
          state_d  = REQ;
        end
      end
      REQ: begin
        if (rd_ack) begin
          rd_req_d = 1'b0;
          cnt_d    = '0;
          state_d  = DATA;
        end
      end
      DATA: begin
        if (rd_valid) begin
          cnt_d = cnt_q + 9'd1;
          if (cnt_d == len_q) begin
            addr_d  = addr_q + ADDR_W'(len_q);
            rem_d   = rem_q - REM_W'(len_q);
            state_d = (rem_d == '0) ? DONE : WAIT_SPACE;
          end
        end
      end
      DONE: begin
        rise_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_133) begin
      state_q   <= IDLE;
      rd_req_q  <= 1'b0;
      bank_q    <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
      rise_q    <= 1'b0;
      skip_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_req_q  <= rd_req_d;
      bank_q    <= bank_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
      rise_q    <= rise_d;
      skip_q    <= skip_d;
    end
  end

  assign rd_req       = rd_req_q;
  assign rd_bank      = bank_q;
  assign rd_addr      = addr_q;
  assign rd_len       = len_q;
  assign fifo_wr_en   = wr_en_q;
  assign fifo_wr_data = wr_data_q;
  assign vga_rise     = rise_q;
  assign frame_skip   = skip_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_frame_reader.sv
// Scoreboard bench for sdram_frame_reader: 8x4 frame, 12-word bursts, 32-word FIFO.
module tb_sdram_frame_reader;

  logic        clk = 1'b0;
  logic        rst_133 = 1'b1;
  logic [1:0]  vga_bank = '0;
  logic        frame_start = 1'b0;
  logic [10:0] fifo_level = '0;
  logic        rd_req;
  logic [1:0]  rd_bank;
  logic [19:0] rd_addr;
  logic [8:0]  rd_len;
  logic        rd_ack = 1'b0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_data = '0;
  logic        fifo_wr_en;
  logic [15:0] fifo_wr_data;
  logic        vga_rise;
  logic        frame_skip;
  logic        busy;

  sdram_frame_reader #(
    .H_PIXELS(8), .V_LINES(4), .BURST_LEN(12), .ADDR_W(20), .FIFO_DEPTH(32)
  ) dut (
    .clk(clk), .rst_133(rst_133), .vga_bank(vga_bank), .frame_start(frame_start),
    .fifo_level(fifo_level), .rd_req(rd_req), .rd_bank(rd_bank), .rd_addr(rd_addr),
    .rd_len(rd_len), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data), .vga_rise(vga_rise),
    .frame_skip(frame_skip), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [30:0] exp_req[$];
  logic [15:0] exp_wr[$];
  int          exp_rise[$];
  int          exp_skip[$];
  logic [15:0] drv_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [30:0] req_word(input logic [1:0] b, input logic [8:0] l,
                                           input logic [19:0] a);
    return {b, l, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an output event.
  logic        req_prev = 1'b0;
  logic        wr_prev  = 1'b0;
  logic [30:0] mon_req;
  logic [15:0] mon_wr;
  always @(negedge clk) begin
    if (rd_req === 1'b1 && req_prev == 1'b0) begin
      chk("req_expected", 64'(exp_req.size() != 0), 64'd1);
      if (exp_req.size() != 0) begin
        mon_req = exp_req.pop_front();
        chk("req_bank_len_addr", 64'({rd_bank, rd_len, rd_addr}), 64'(mon_req));
      end
    end
    if (fifo_wr_en === 1'b1) begin
      chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
      if (exp_wr.size() != 0) begin
        mon_wr = exp_wr.pop_front();
        chk("wr_data", 64'(fifo_wr_data), 64'(mon_wr));
      end
    end
    if (vga_rise === 1'b1) begin
      chk("rise_expected", 64'(exp_rise.size() != 0), 64'd1);
      chk("rise_after_last_wr", 64'(wr_prev), 64'd1);
      chk("rise_all_data_seen", 64'(exp_wr.size()), 64'd0);
      if (exp_rise.size() != 0) void'(exp_rise.pop_front());
    end
    if (frame_skip === 1'b1) begin
      chk("skip_expected", 64'(exp_skip.size() != 0), 64'd1);
      if (exp_skip.size() != 0) void'(exp_skip.pop_front());
    end
    req_prev <= (rd_req === 1'b1);
    wr_prev  <= (fifo_wr_en === 1'b1);
  end

  task automatic push_frame(input logic [1:0] b, input logic [15:0] base);
    exp_req.push_back(req_word(b, 9'd12, 20'd0));
    exp_req.push_back(req_word(b, 9'd12, 20'd12));
    exp_req.push_back(req_word(b, 9'd8, 20'd24));
    for (int i = 0; i < 32; i++) exp_wr.push_back(base + 16'(i));
    exp_rise.push_back(1);
    drv_data = base;
  endtask

  task automatic start_frame(input logic [1:0] b);
    vga_bank    = b;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  // Controller model: ack 3 cycles after the request, then return rd_len words.
  task automatic do_burst(input bit inject, input int nwords_max);
    int w;
    int len;
    w = 0;
    while (rd_req !== 1'b1 && w < 200) begin tick(); w++; end
    if (rd_req !== 1'b1) begin
      chk("req_timeout", 64'(rd_req), 64'd1);
      return;
    end
    repeat (3) tick();
    len = int'(rd_len);
    if (len == 0 || len > 12) len = 12;
    if (nwords_max < len) len = nwords_max;
    rd_ack = 1'b1;
    tick();
    rd_ack = 1'b0;
    for (int i = 0; i < len; i++) begin
      rd_valid = 1'b1;
      rd_data  = drv_data;
      drv_data = drv_data + 16'd1;
      if (inject && i == 3) begin
        frame_start = 1'b1;
        vga_bank    = 2'd1;
        exp_skip.push_back(1);
      end
      tick();
      frame_start = 1'b0;
    end
    rd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    while (busy === 1'b1 && w < 50) begin tick(); w++; end
    chk("frame_done", 64'(busy), 64'd0);
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    chk({tag, "_rd_bank"}, 64'(rd_bank), 64'd0);
    chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_rd_len"}, 64'(rd_len), 64'd0);
    chk({tag, "_fifo_wr_en"}, 64'(fifo_wr_en), 64'd0);
    chk({tag, "_fifo_wr_data"}, 64'(fifo_wr_data), 64'd0);
    chk({tag, "_vga_rise"}, 64'(vga_rise), 64'd0);
    chk({tag, "_frame_skip"}, 64'(frame_skip), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    bit saw_req;

    // Reset then idle
    rst_133 = 1'b1;
    repeat (3) tick();
    rst_133 = 1'b0;
    repeat (10) tick();
    check_reset_outputs("idle");

    // Basic frame from bank 2, FIFO empty
    push_frame(2'd2, 16'h0100);
    start_frame(2'd2);
    chk("req_not_before_n2", 64'(rd_req), 64'd0);
    tick();
    chk("req_at_n2", 64'(rd_req), 64'd1);
    for (int b = 0; b < 3; b++) do_burst(1'b0, 12);
    wait_idle();

    // Spurious rd_valid in IDLE
    for (int i = 0; i < 3; i++) begin
      rd_valid = 1'b1; rd_data = 16'hdead; tick();
    end
    rd_valid = 1'b0;
    tick();
    chk("idle_busy_after_spurious", 64'(busy), 64'd0);

    // FIFO nearly full, with spurious rd_valid/rd_ack while waiting for space
    fifo_level = 11'd25;
    push_frame(2'd0, 16'h0200);
    start_frame(2'd0);
    saw_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rd_valid = 1'b1; rd_data = 16'hbeef; rd_ack = i[0];
      tick();
      saw_req = saw_req | (rd_req === 1'b1);
    end
    rd_valid = 1'b0; rd_ack = 1'b0;
    chk("no_req_level25", 64'(saw_req), 64'd0);
    chk("busy_waiting", 64'(busy), 64'd1);
    fifo_level = 11'd21;
    repeat (3) tick();
    chk("no_req_level21", 64'(rd_req), 64'd0);
    fifo_level = 11'd20;
    n = 0;
    while (rd_req !== 1'b1 && n < 10) begin tick(); n++; end
    chk("req_within_2_after_space", 64'(n <= 2), 64'd1);
    for (int b = 0; b < 3; b++) do_burst(1'b0, 12);
    wait_idle();
    fifo_level = 11'd0;

    // frame_start during DATA with a bank change mid-frame
    push_frame(2'd2, 16'h0300);
    start_frame(2'd2);
    do_burst(1'b1, 12);
    do_burst(1'b0, 12);
    do_burst(1'b0, 12);
    wait_idle();

    // Reset during the second burst's DATA
    exp_req.push_back(req_word(2'd3, 9'd12, 20'd0));
    exp_req.push_back(req_word(2'd3, 9'd12, 20'd12));
    for (int i = 0; i < 16; i++) exp_wr.push_back(16'h0400 + 16'(i));
    drv_data = 16'h0400;
    start_frame(2'd3);
    do_burst(1'b0, 12);
    do_burst(1'b0, 4);
    rst_133 = 1'b1;
    tick();
    check_reset_outputs("midburst_reset");
    rst_133 = 1'b0;
    repeat (2) tick();
    chk("reset_req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("reset_wr_queue_empty", 64'(exp_wr.size()), 64'd0);

    // Fresh frame after reset restarts at address 0
    push_frame(2'd1, 16'h0500);
    start_frame(2'd1);
    for (int b = 0; b < 3; b++) do_burst(1'b0, 12);
    wait_idle();

    chk("end_req_queue_empty", 64'(exp_req.size()), 64'd0);
    chk("end_wr_queue_empty", 64'(exp_wr.size()), 64'd0);
    chk("end_rise_queue_empty", 64'(exp_rise.size()), 64'd0);
    chk("end_skip_queue_empty", 64'(exp_skip.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
